// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed hex 7-segment scanner.
// Shadowed data, blanking, PWM dimming, digit mask, dp, zero suppression.
module seg_scan_display #(
  parameter int DIGITS       = 8,
  parameter int DWELL        = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   disp_num,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_suppress,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     digit_anode,
  output logic [7:0]            segment,
  output logic                  frame_tick
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_t;

  logic [4*DIGITS-1:0] r_num;
  logic [DIGITS-1:0]   r_dp;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  state_t              r_state;
  logic [DIGITS-1:0]   r_anode;
  logic [7:0]          r_seg;
  logic                r_tick;

  logic                w_cnt_wrap;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_tick_nxt;
  state_t              w_state_nxt;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_en;
  logic                w_sup;
  logic                w_pwm;
  logic                w_show;
  logic [DIGITS-1:0]   w_anode_nxt;
  logic [7:0]          w_seg_nxt;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    unique case (n)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  // Shadow copy of the display word, captured only on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num <= '0;
      r_dp  <= '0;
    end else if (load) begin
      r_num <= disp_num;
      r_dp  <= dp_in;
    end
  end

  assign w_cnt_wrap = (r_cnt == CNT_MAX);
  assign w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + 1'b1;
  assign w_tick_nxt = w_cnt_wrap && (r_idx == IDX_MAX);

  // Slot index advances once per dwell wrap.
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_cnt_wrap) begin
      w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
  end

  // Dwell counter and scan index; timing never depends on data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BLANK;
    else        r_state <= w_state_nxt;
  end

  // Next state: blank at slot start, on for the remainder.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BLANK: begin
        if (w_cnt_nxt >= BLANK_C) w_state_nxt = ST_ON;
      end
      ST_ON: begin
        if ((BLANK_CYCLES != 0) && w_cnt_wrap) w_state_nxt = ST_BLANK;
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // Pick the upcoming slot's nibble, flags and zero-suppression status.
  always_comb begin
    logic v_live;
    w_nib  = '0;
    w_dp   = 1'b0;
    w_en   = 1'b0;
    w_sup  = 1'b0;
    v_live = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_live = v_live | (|r_num[4*i +: 4]);
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib = r_num[4*i +: 4];
        w_dp  = r_dp[i];
        w_en  = digit_en[i];
        w_sup = lz_suppress && (i > 0) && !v_live;
      end
    end
  end

  assign w_pwm = (brightness != 4'd0) &&
                 (w_cnt_nxt[3:0] <= brightness);
  assign w_show = (w_state_nxt == ST_ON) && w_en && w_pwm &&
                  (!w_sup || w_dp);

  // Anode and segment terms come from one decision so they stay aligned.
  always_comb begin
    w_anode_nxt = '1;
    w_seg_nxt   = 8'hFF;
    if (w_show) begin
      w_anode_nxt = ~(DIGITS'(1) << w_idx_nxt);
      w_seg_nxt   = {~w_dp, (w_sup ? 7'h7F : font(w_nib))};
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anode <= '1;
      r_seg   <= 8'hFF;
      r_tick  <= 1'b0;
    end else begin
      r_anode <= w_anode_nxt;
      r_seg   <= w_seg_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign digit_anode = r_anode;
  assign segment     = r_seg;
  assign frame_tick  = r_tick;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of the scanner.
// Main instance 8 digits / dwell 32 / blank 4, plus a 1-digit instance.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] disp_num = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [7:0]  digit_anode;
  logic [7:0]  segment;
  logic        frame_tick;

  logic [3:0]  d1_num = 4'h5;
  logic        d1_dp = 1'b0;
  logic        d1_en = 1'b1;
  logic        d1_anode;
  logic [7:0]  d1_seg;
  logic        d1_tick;

  int k;
  int n_chk = 0;
  int n_fail = 0;

  seg_scan_display #(
    .DIGITS(8), .DWELL(32), .BLANK_CYCLES(4), .IDX_W(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .disp_num(disp_num), .dp_in(dp_in),
    .digit_en(digit_en), .lz_suppress(lz_suppress),
    .brightness(brightness), .digit_anode(digit_anode),
    .segment(segment), .frame_tick(frame_tick)
  );

  seg_scan_display #(
    .DIGITS(1), .DWELL(32), .BLANK_CYCLES(4), .IDX_W(1)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .disp_num(d1_num), .dp_in(d1_dp),
    .digit_en(d1_en), .lz_suppress(1'b0),
    .brightness(4'd15), .digit_anode(d1_anode),
    .segment(d1_seg), .frame_tick(d1_tick)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; output at k reflects dwell count k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic at(input int p);
    while (k < p) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(digit_anode), 32'hFF);
    chk("rst_seg", 32'(segment), 32'hFF);
    chk("rst_tick", 32'(frame_tick), 32'h0);

    rst_n = 1'b1;
    disp_num = 32'h0012_3456;
    dp_in = 8'h04;
    load = 1'b1;
    at(1);
    load = 1'b0;

    at(3);   chk("blank_k3", 32'(digit_anode), 32'hFF);
    at(4);   chk("s0_anode", 32'(digit_anode), 32'hFE);
             chk("s0_seg", 32'(segment), 32'h82);
             chk("d1_anode", 32'(d1_anode), 32'h0);
             chk("d1_seg", 32'(d1_seg), 32'h92);
    at(31);  chk("s0_end", 32'(digit_anode), 32'hFE);
             chk("d1_tick_31", 32'(d1_tick), 32'h0);
    at(32);  chk("s1_start", 32'(digit_anode), 32'hFF);
             chk("d1_tick_32", 32'(d1_tick), 32'h1);
    at(33);  chk("d1_tick_33", 32'(d1_tick), 32'h0);
    at(64);  chk("d1_tick_64", 32'(d1_tick), 32'h1);
    at(68);  chk("s2_anode", 32'(digit_anode), 32'hFB);
             chk("s2_seg", 32'(segment), 32'h19);
    at(196); chk("s6_anode", 32'(digit_anode), 32'hBF);
             chk("s6_seg", 32'(segment), 32'hC0);
    at(228); chk("s7_anode", 32'(digit_anode), 32'h7F);
             chk("s7_seg", 32'(segment), 32'hC0);
    at(255); chk("tick_255", 32'(frame_tick), 32'h0);
    at(256); chk("tick_256", 32'(frame_tick), 32'h1);
    at(257); chk("tick_257", 32'(frame_tick), 32'h0);
    at(259); chk("f1_blank", 32'(digit_anode), 32'hFF);

    at(300); lz_suppress = 1'b1;
    at(420); chk("lz_s5_anode", 32'(digit_anode), 32'hDF);
             chk("lz_s5_seg", 32'(segment), 32'hF9);
    at(452); chk("lz_s6", 32'(digit_anode), 32'hFF);
    at(484); chk("lz_s7", 32'(digit_anode), 32'hFF);
    at(511); chk("tick_511", 32'(frame_tick), 32'h0);
    at(512); chk("tick_512", 32'(frame_tick), 32'h1);

    at(520);
    dp_in = 8'h84;
    load = 1'b1;
    at(521); load = 1'b0;
    at(708); chk("lzdp_s6", 32'(digit_anode), 32'hFF);
    at(740); chk("lzdp_s7_anode", 32'(digit_anode), 32'h7F);
             chk("lzdp_s7_seg", 32'(segment), 32'h7F);

    at(770);
    lz_suppress = 1'b0;
    digit_en = 8'hFD;
    at(804); chk("mask_s1_a", 32'(digit_anode), 32'hFF);
    at(831); chk("mask_s1_b", 32'(digit_anode), 32'hFF);
    at(836); chk("mask_s2_anode", 32'(digit_anode), 32'hFB);
             chk("mask_s2_seg", 32'(segment), 32'h19);
    at(840); digit_en = 8'hFF;

    at(1030); brightness = 4'd7;
    at(1063); chk("b7_c7", 32'(digit_anode), 32'hFD);
    at(1064); chk("b7_c8", 32'(digit_anode), 32'hFF);
    at(1072); chk("b7_c16", 32'(digit_anode), 32'hFD);
    at(1080); chk("b7_c24", 32'(digit_anode), 32'hFF);
    at(1100); brightness = 4'd0;
    at(1124); chk("b0_c4", 32'(digit_anode), 32'hFF);
    at(1140); chk("b0_c20", 32'(digit_anode), 32'hFF);
    at(1150); chk("b0_c30", 32'(digit_anode), 32'hFF);
    at(1200); brightness = 4'd15;

    at(1385);
    disp_num = 32'h0012_9456;
    dp_in = 8'h04;
    load = 1'b1;
    at(1386); chk("mid_old_anode", 32'(digit_anode), 32'hF7);
              chk("mid_old_seg", 32'(segment), 32'hB0);
              load = 1'b0;
    at(1387); chk("mid_new_anode", 32'(digit_anode), 32'hF7);
              chk("mid_new_seg", 32'(segment), 32'h90);
    at(1535); chk("tick_1535", 32'(frame_tick), 32'h0);
    at(1536); chk("tick_1536", 32'(frame_tick), 32'h1);

    at(1610); chk("pre_rst", 32'(digit_anode), 32'hFB);
    #2 rst_n = 1'b0;
    #1;
    chk("async_anode", 32'(digit_anode), 32'hFF);
    chk("async_seg", 32'(segment), 32'hFF);
    chk("async_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    at(3); chk("rr_blank", 32'(digit_anode), 32'hFF);
    at(4); chk("rr_anode", 32'(digit_anode), 32'hFE);
           chk("rr_seg", 32'(segment), 32'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
